// File: rtl/jt12_kon_seq.sv
// jt12_kon_seq: key-on/key-off sequencer for the JT12 operator pipeline.
// Register-0x28 style writes enter a small pending queue. One entry is applied
// per frame, on the cycle where next_slot is the last slot. A persistent key
// state is kept for every slot, and the key level plus one-shot on/off edge
// pulses are streamed to the envelope generator in slot order.
// Optional feature: define JT12_KON_CSM_EN to enable the CSM forced key-on of
// channel index 2, triggered by csm_trig.
module jt12_kon_seq #(
    parameter int NCH    = 6,
    parameter int NOP    = 4,
    parameter int SW     = 5,
    parameter int QDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] next_slot,
    input  logic          up_keyon,
    input  logic [2:0]    keyon_ch,
    input  logic [3:0]    keyon_op,
    input  logic          csm_trig,
    output logic          key_level,
    output logic          keyon_II,
    output logic          keyoff_II,
    output logic          busy,
    output logic          full,
    output logic          ovf
);
    localparam int NS = NCH * NOP;
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(NS - 1);

    // Queue storage: {channel index, operator mask}.
    logic [6:0]    q_mem [0:QDEPTH-1];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;

    logic [NS-1:0] state_reg, state_next;
    logic [NS-1:0] pend_on_reg, pend_on_next;
    logic [NS-1:0] pend_off_reg, pend_off_next;
    logic [NS-1:0] sel, eff_old, eff_new;

    logic key_level_reg, keyon_reg, keyoff_reg, ovf_reg;

    logic       ch_valid;
    logic [2:0] ch_idx;
    logic       apply_pt, pop, push, push_rej;
    logic [2:0] head_ch;
    logic [3:0] head_mask;

    // Decode the channel code into a dense index; codes 3 and 7 are holes.
    always_comb begin
        ch_valid = 1'b0;
        ch_idx   = 3'd0;
        case (keyon_ch)
            3'd0, 3'd1, 3'd2: begin
                ch_valid = 1'b1;
                ch_idx   = keyon_ch;
            end
            3'd4, 3'd5, 3'd6: begin
                ch_valid = (NCH == 6);
                ch_idx   = keyon_ch - 3'd1;
            end
            default: begin
                ch_valid = 1'b0;
                ch_idx   = 3'd0;
            end
        endcase
    end

    assign apply_pt  = (next_slot == LAST_SLOT);
    assign pop       = apply_pt && (count_reg != '0);
    // A pop in the same cycle frees an entry, so a push while full still fits.
    assign push      = up_keyon && ch_valid && ((count_reg != CW'(QDEPTH)) || pop);
    assign push_rej  = up_keyon && !push;
    assign head_ch   = q_mem[rd_ptr_reg][6:4];
    assign head_mask = q_mem[rd_ptr_reg][3:0];

    // Occupancy tracking for simultaneous push/pop.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

`ifdef JT12_KON_CSM_EN
    logic          csm_pend_reg, csm_pend_next;
    logic          force_reg, force_next;
    logic [NS-1:0] force_vec, force_next_vec;

    // The force is re-evaluated at every apply point, so it lasts exactly one frame.
    always_comb begin
        force_next    = apply_pt ? csm_pend_reg : force_reg;
        csm_pend_next = (csm_pend_reg && !apply_pt) || csm_trig;
    end
`else
    logic unused_csm;
    assign unused_csm = csm_trig;
`endif

    // Per-slot state update and slot decode; group g uses mask bit 0,2,1,3.
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slot
            localparam int GRP = gi / NCH;
            localparam int CH  = gi % NCH;
            localparam int MB  = (GRP == 1) ? 2 : ((GRP == 2) ? 1 : GRP);
            assign state_next[gi] = (pop && (head_ch == 3'(CH))) ? head_mask[MB]
                                                                  : state_reg[gi];
            assign sel[gi] = (next_slot == SW'(gi));
`ifdef JT12_KON_CSM_EN
            assign force_vec[gi]      = (CH == 2) && force_reg;
            assign force_next_vec[gi] = (CH == 2) && force_next;
`endif
        end
    endgenerate

    // Edges are detected on the effective level (register state plus any force).
`ifdef JT12_KON_CSM_EN
    assign eff_old = state_reg | force_vec;
    assign eff_new = state_next | force_next_vec;
`else
    assign eff_old = state_reg;
    assign eff_new = state_next;
`endif

    // A newly applied edge wins over the clear of the slot sampled this cycle.
    assign pend_on_next  = (pend_on_reg  & ~sel) | (eff_new & ~eff_old);
    assign pend_off_next = (pend_off_reg & ~sel) | (eff_old & ~eff_new);

    // Queue storage write; contents need no reset because count gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_reg] <= {ch_idx, keyon_op};
        end
    end

    // Control, key state and registered slot outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            state_reg     <= '0;
            pend_on_reg   <= '0;
            pend_off_reg  <= '0;
            key_level_reg <= 1'b0;
            keyon_reg     <= 1'b0;
            keyoff_reg    <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg     <= count_next;
            state_reg     <= state_next;
            pend_on_reg   <= pend_on_next;
            pend_off_reg  <= pend_off_next;
            key_level_reg <= |(eff_old & sel);
            keyon_reg     <= |(pend_on_reg & sel);
            keyoff_reg    <= |(pend_off_reg & sel);
            if (push_rej) ovf_reg <= 1'b1;
        end
    end

`ifdef JT12_KON_CSM_EN
    // CSM trigger latch and one-frame force register.
    always_ff @(posedge clk) begin
        if (rst) begin
            csm_pend_reg <= 1'b0;
            force_reg    <= 1'b0;
        end else begin
            csm_pend_reg <= csm_pend_next;
            force_reg    <= force_next;
        end
    end
`endif

    assign key_level = key_level_reg;
    assign keyon_II  = keyon_reg;
    assign keyoff_II = keyoff_reg;
    assign ovf       = ovf_reg;
    assign busy      = (count_reg != '0);
    assign full      = (count_reg == CW'(QDEPTH));

endmodule

// File: tb/tb_jt12_kon_seq.sv
// Directed bench for jt12_kon_seq with NCH=6, QDEPTH=4 (24 slots per frame).
module tb_jt12_kon_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] next_slot = '0;
    logic       up_keyon = 1'b0;
    logic [2:0] keyon_ch = '0;
    logic [3:0] keyon_op = '0;
    logic       csm_trig = 1'b0;
    logic       key_level, keyon_II, keyoff_II, busy, full, ovf;

    int checks = 0;
    int failures = 0;
    int cur_slot = 0;
    logic [23:0] on_v, off_v, lvl_v;

    jt12_kon_seq #(.NCH(6), .NOP(4), .SW(5), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst), .next_slot(next_slot), .up_keyon(up_keyon),
        .keyon_ch(keyon_ch), .keyon_op(keyon_op), .csm_trig(csm_trig),
        .key_level(key_level), .keyon_II(keyon_II), .keyoff_II(keyoff_II),
        .busy(busy), .full(full), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present cur_slot for one cycle and record the outputs it produces.
    task automatic tick();
        next_slot = 5'(cur_slot);
        @(posedge clk);
        #1;
        up_keyon = 1'b0;
        csm_trig = 1'b0;
        on_v[cur_slot]  = keyon_II;
        off_v[cur_slot] = keyoff_II;
        lvl_v[cur_slot] = key_level;
        cur_slot = (cur_slot == 23) ? 0 : cur_slot + 1;
    endtask

    task automatic write(input logic [2:0] ch, input logic [3:0] op);
        up_keyon = 1'b1;
        keyon_ch = ch;
        keyon_op = op;
        tick();
        $display("write ch=%0d op=%b busy=%0b full=%0b ovf=%0b", ch, op, busy, full, ovf);
    endtask

    task automatic run_rest();
        while (cur_slot != 0) tick();
    endtask

    task automatic goto_slot(input int s);
        while (cur_slot != s) tick();
    endtask

    task automatic run_frame();
        on_v = '0; off_v = '0; lvl_v = '0;
        for (int i = 0; i < 24; i++) tick();
        $display("frame on=%h off=%h lvl=%h busy=%0b", on_v, off_v, lvl_v, busy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cur_slot = 0;
    endtask

    initial begin
        do_reset();
        chk("rst_level", {31'd0, key_level}, 32'd0);
        chk("rst_on", {31'd0, keyon_II}, 32'd0);
        chk("rst_off", {31'd0, keyoff_II}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);

        // ch1 all operators on: slots 1,7,13,19
        write(3'd1, 4'hF);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        run_rest();
        run_frame();
        chk("t1_on", 32'(on_v), 32'h082082);
        chk("t1_off", 32'(off_v), 32'h0);
        chk("t1_lvl", 32'(lvl_v), 32'h082082);
        run_frame();
        chk("t1_on2", 32'(on_v), 32'h0);
        chk("t1_lvl2", 32'(lvl_v), 32'h082082);

        // ch4 op1+op3 on, then all off: slots 3 and 9
        write(3'd4, 4'b0101);
        write(3'd4, 4'b0000);
        run_rest();
        chk("t2_busy1", {31'd0, busy}, 32'd1);
        run_frame();
        chk("t2_on", 32'(on_v), 32'h000208);
        chk("t2_lvl", 32'(lvl_v), 32'h08228A);
        chk("t2_busy2", {31'd0, busy}, 32'd0);
        run_frame();
        chk("t2_off", 32'(off_v), 32'h000208);
        chk("t2_on2", 32'(on_v), 32'h0);
        chk("t2_lvl2", 32'(lvl_v), 32'h082082);

        // Overflow: five writes with no apply point between them
        for (int i = 0; i < 4; i++) write(3'd5, 4'h0);
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_ovf0", {31'd0, ovf}, 32'd0);
        write(3'd5, 4'h0);
        chk("t3_ovf", {31'd0, ovf}, 32'd1);
        chk("t3_full2", {31'd0, full}, 32'd1);
        run_rest();
        chk("t3_full3", {31'd0, full}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) run_frame();
        chk("t3_busy2", {31'd0, busy}, 32'd0);
        chk("t3_on", 32'(on_v), 32'h0);

        // Reset mid-operation drops the queue and all key state
        write(3'd0, 4'hF);
        do_reset();
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_ovf", {31'd0, ovf}, 32'd0);
        run_frame();
        run_frame();
        chk("t4_lvl", 32'(lvl_v), 32'h0);
        chk("t4_on", 32'(on_v), 32'h0);

        // Push while full on the apply cycle is accepted
        goto_slot(19);
        for (int i = 0; i < 4; i++) write(3'd5, 4'h0);
        chk("t5_full", {31'd0, full}, 32'd1);
        write(3'd5, 4'h0);
        chk("t5_ovf", {31'd0, ovf}, 32'd0);
        chk("t5_full2", {31'd0, full}, 32'd1);
        for (int i = 0; i < 4; i++) run_frame();
        chk("t5_busy", {31'd0, busy}, 32'd0);

        // Invalid channel code 3
        write(3'd3, 4'hF);
        chk("t6_ovf", {31'd0, ovf}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        run_rest();
        run_frame();
        chk("t6_on", 32'(on_v), 32'h0);

        // Repeated key-on of ch0 does not retrigger: slots 0,6,12,18
        write(3'd0, 4'hF);
        run_rest();
        run_frame();
        chk("t7_on", 32'(on_v), 32'h041041);
        write(3'd0, 4'hF);
        run_rest();
        run_frame();
        chk("t7_on2", 32'(on_v), 32'h0);
        chk("t7_lvl", 32'(lvl_v), 32'h041041);

`ifdef JT12_KON_CSM_EN
        // CSM forced key-on of channel index 2: slots 2,8,14,20
        do_reset();
        csm_trig = 1'b1;
        tick();
        run_rest();
        run_frame();
        chk("csm_on", 32'(on_v), 32'h104104);
        chk("csm_lvl", 32'(lvl_v), 32'h104104);
        run_frame();
        chk("csm_off", 32'(off_v), 32'h104104);
        chk("csm_on2", 32'(on_v), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
